// File: rtl/regfile_nport.sv
// Multi-read-port, single-write-port register file for the ID stage.
// It holds the architectural registers and has one write port, driven from WB.
// Each read port has its own balanced 2:1 mux tree, so no port is favoured.
// Optional features:
//   - Write-to-read bypass, so a read sees this cycle's write data.
//   - One cycle of registered read latency.
// One index (ZERO_REG) is hardwired to zero. Setting ZERO_REG to DEPTH or above disables it.

module regfile_nport #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 31,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          READ_REG = 1'b0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [NREAD-1:0][AW-1:0]     rd_addr,
    output logic [NREAD-1:0][WIDTH-1:0]  rd_data
);

    // The mux tree is built over a power-of-two leaf count.
    // Leaves at index DEPTH and above are tied to zero.
    localparam int unsigned NLEAF = 1 << AW;

    // An index is "live" if it is in range and is not the hardwired zero register.
    // Only live indices are ever written or read from storage.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && (32'(a) != ZERO_REG);
    endfunction

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             wr_ok;

    assign wr_ok = wr_en && addr_live(wr_addr);

    // Architectural state. Reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Leaf values shared by all ports.
    // The zero register and padding leaves are forced to 0 here, not read from storage.
    logic [WIDTH-1:0] leaf [NLEAF];

    for (genvar k = 0; k < int'(NLEAF); k++) begin : g_leaf
        if ((k < int'(DEPTH)) && (k != int'(ZERO_REG))) begin : g_store
            assign leaf[k] = regs_q[k];
        end else begin : g_zero
            assign leaf[k] = '0;
        end
    end

    for (genvar p = 0; p < int'(NREAD); p++) begin : g_port
        logic [WIDTH-1:0] tree_out;
        logic [WIDTH-1:0] val;
        logic             hit;
        logic             live;

        // Balanced select tree.
        // Level l has NLEAF>>l nodes and is steered by address bit l-1.
        for (genvar l = 0; l <= int'(AW); l++) begin : g_lvl
            logic [WIDTH-1:0] node [NLEAF >> l];
            if (l == 0) begin : g_base
                for (genvar i = 0; i < int'(NLEAF); i++) begin : g_in
                    assign node[i] = leaf[i];
                end
            end else begin : g_mux
                for (genvar i = 0; i < int'(NLEAF >> l); i++) begin : g_sel
                    assign node[i] = rd_addr[p][l-1] ? g_lvl[l-1].node[2*i+1]
                                                     : g_lvl[l-1].node[2*i];
                end
            end
        end

        assign tree_out = g_lvl[AW].node[0];
        assign live     = addr_live(rd_addr[p]);

        // A read that is not live needs no bypass check: it reads 0 regardless.
        // Reset suppresses bypass because the write it would forward is dropped.
        assign hit = BYPASS && wr_en && !reset && (wr_addr == rd_addr[p]);

        // Per-port read value: zero, bypassed write data, or stored value.
        always_comb begin
            val = tree_out;
            if (!live) begin
                val = '0;
            end else if (hit) begin
                val = wr_data;
            end
        end

        if (READ_REG) begin : g_rreg
            logic [WIDTH-1:0] rd_q;

            // Registered read: one cycle of latency, cleared by reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= val;
                end
            end

            assign rd_data[p] = rd_q;
        end else begin : g_comb
            assign rd_data[p] = val;
        end
    end

endmodule

// File: tb/tb_regfile_nport.sv
// Directed bench for regfile_nport. It drives the same inputs into two instances.
//   dut_a: defaults. DEPTH=32, XZR=31, bypass on, combinational read.
//   dut_b: DEPTH=24, zero register 23, bypass off, registered read.
// dut_a is checked just before each edge. dut_b is checked just after the edge,
// where it shows the value captured from the inputs of the cycle before.

module tb_regfile_nport;

    logic            clk;
    logic            reset;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [63:0]     wr_data;
    logic [1:0][4:0] rd_addr;
    logic [1:0][63:0] rd_a;
    logic [1:0][63:0] rd_b;

    int n_run;
    int n_fail;

    regfile_nport dut_a (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_a)
    );

    regfile_nport #(
        .DEPTH    (24),
        .ZERO_REG (23),
        .BYPASS   (1'b0),
        .READ_REG (1'b1)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dut_b holds a one-hot pattern only at indices 0..22.
    // Index 23 is its zero register, and 24 and above are out of range.
    function automatic logic [63:0] exp_b(input int idx);
        return (idx < 23) ? (64'h1 << idx) : 64'h0;
    endfunction

    // Read back the one-hot pattern: port 0 gets index i, port 1 gets index 30-i.
    task automatic read_all(input string tag);
        for (int i = 0; i <= 30; i++) begin
            wr_en      = 1'b0;
            rd_addr[0] = 5'(i);
            rd_addr[1] = 5'(30 - i);
            #1;
            chk({tag, "_a0"}, rd_a[0], 64'h1 << i);
            chk({tag, "_a1"}, rd_a[1], 64'h1 << (30 - i));
            tick();
            chk({tag, "_b0"}, rd_b[0], exp_b(i));
            chk({tag, "_b1"}, rd_b[1], exp_b(30 - i));
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;

        // Reset, with a write pending that must be dropped.
        reset      = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 5'd3;
        wr_data    = 64'h77;
        rd_addr[0] = 5'd0;
        rd_addr[1] = 5'd0;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;

        // Every index reads 0 after reset.
        for (int i = 0; i < 32; i++) begin
            rd_addr[0] = 5'(i);
            rd_addr[1] = 5'(31 - i);
            #1;
            chk("rst_a0", rd_a[0], 64'h0);
            chk("rst_a1", rd_a[1], 64'h0);
            tick();
            chk("rst_b0", rd_b[0], 64'h0);
            chk("rst_b1", rd_b[1], 64'h0);
        end

        // Write a one-hot pattern, then read it back on both ports.
        for (int i = 0; i <= 30; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = 64'h1 << i;
            tick();
        end
        read_all("wrrd");

        // XZR: a write to index 31 is not bypassed and not stored.
        wr_en      = 1'b1;
        wr_addr    = 5'd31;
        wr_data    = 64'hDEAD_BEEF_0000_0001;
        rd_addr[0] = 5'd31;
        rd_addr[1] = 5'd30;
        #1;
        chk("xzr_byp_a0", rd_a[0], 64'h0);
        chk("xzr_byp_a1", rd_a[1], 64'h4000_0000);
        tick();
        chk("xzr_byp_b0", rd_b[0], 64'h0);
        chk("xzr_byp_b1", rd_b[1], 64'h0);
        wr_en      = 1'b0;
        rd_addr[1] = 5'd0;
        #1;
        chk("xzr_late_a0", rd_a[0], 64'h0);
        chk("xzr_late_a1", rd_a[1], 64'h1);
        tick();
        chk("xzr_late_b0", rd_b[0], 64'h0);
        chk("xzr_late_b1", rd_b[1], 64'h1);
        read_all("xzr_keep");

        // Bypass: reg[5]=A, then write B while both ports read 5.
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 64'hA;
        tick();
        wr_data    = 64'hB;
        rd_addr[0] = 5'd5;
        rd_addr[1] = 5'd5;
        #1;
        chk("byp_a0", rd_a[0], 64'hB);
        chk("byp_a1", rd_a[1], 64'hB);
        tick();
        chk("nobyp_b0", rd_b[0], 64'hA);
        chk("nobyp_b1", rd_b[1], 64'hA);
        wr_en = 1'b0;
        #1;
        chk("byp_next_a0", rd_a[0], 64'hB);
        chk("byp_next_a1", rd_a[1], 64'hB);
        tick();
        chk("byp_next_b0", rd_b[0], 64'hB);
        chk("byp_next_b1", rd_b[1], 64'hB);

        // Reset mid-operation. The write of 77 is neither stored nor forwarded.
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 64'h55;
        tick();
        reset      = 1'b1;
        wr_data    = 64'h77;
        rd_addr[0] = 5'd3;
        rd_addr[1] = 5'd5;
        #1;
        chk("rstmid_a0", rd_a[0], 64'h55);
        chk("rstmid_a1", rd_a[1], 64'hB);
        tick();
        chk("rstmid_b0", rd_b[0], 64'h0);
        chk("rstmid_b1", rd_b[1], 64'h0);
        reset = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("rstpost_a0", rd_a[0], 64'h0);
        chk("rstpost_a1", rd_a[1], 64'h0);
        tick();
        chk("rstpost_b0", rd_b[0], 64'h0);
        chk("rstpost_b1", rd_b[1], 64'h0);

        // Non-power-of-two depth: index 27 is out of range for dut_b.
        // Index 22 is its last real register, and 23 is its zero register.
        wr_en   = 1'b1;
        wr_addr = 5'd27;
        wr_data = 64'h99;
        tick();
        wr_addr = 5'd22;
        wr_data = 64'h1234;
        tick();
        wr_addr = 5'd23;
        wr_data = 64'h5;
        tick();
        wr_en      = 1'b0;
        rd_addr[0] = 5'd27;
        rd_addr[1] = 5'd22;
        #1;
        chk("np2_a0", rd_a[0], 64'h99);
        chk("np2_a1", rd_a[1], 64'h1234);
        tick();
        chk("np2_b0", rd_b[0], 64'h0);
        chk("np2_b1", rd_b[1], 64'h1234);
        rd_addr[0] = 5'd23;
        rd_addr[1] = 5'd23;
        #1;
        chk("np2z_a0", rd_a[0], 64'h5);
        chk("np2z_a1", rd_a[1], 64'h5);
        tick();
        chk("np2z_b0", rd_b[0], 64'h0);
        chk("np2z_b1", rd_b[1], 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_nport.md
Name: regfile_nport

Overview:
Parametrised multi-read-port, single-write-port register file for the pipelined CPU datapath. It generalises the 64-bit 32:1 register-read mux into a block that does three things: holds the architectural registers, drives NREAD independent read ports through per-port select trees, and provides write-to-read bypass and an optional registered-read mode. It sits at the ID stage; the write port is driven from WB.

Parameters:
WIDTH, 64, data bits per register
DEPTH, 32, number of registers (2..64, need not be a power of two)
NREAD, 2, number of independent read ports (1..4)
ZERO_REG, 31, index hardwired to zero (XZR); DEPTH or above disables the feature
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
READ_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency)
AW (localparam), $clog2(DEPTH), address width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write enable
wr_addr  in  AW  write register index
wr_data  in  WIDTH  write data
rd_addr  in  NREAD x AW  packed array, one read index per port
rd_data  out  NREAD x WIDTH  packed array, one read value per port

Behaviour:
- Storage: DEPTH x WIDTH flops. On a rising edge with reset=1, every register clears to 0.
- Reset takes priority over wr_en. A write presented in a reset cycle is dropped.
- Write: on a rising edge with reset=0, wr_en=1, wr_addr<DEPTH and wr_addr!=ZERO_REG, reg[wr_addr] takes wr_data. All other cases leave storage unchanged.
- ZERO_REG: always reads 0 and is never written, including on bypass.
- Read value per port p, call it val_p:
  - 0 if rd_addr[p]>=DEPTH or rd_addr[p]==ZERO_REG.
  - Otherwise, if BYPASS=1, wr_en=1, reset=0 and wr_addr==rd_addr[p]: wr_data.
  - Otherwise: reg[rd_addr[p]].
- Bypass is evaluated independently per port, so several ports may bypass in the same cycle.
- READ_REG=0:
  - rd_data[p]=val_p combinationally, with zero-cycle latency.
  - After a reset edge, all rd_data read 0.
- READ_REG=1:
  - rd_data[p] is a flop loaded with val_p each rising edge, giving 1-cycle latency.
  - On a reset edge, rd_data clears to 0.
  - With BYPASS=0 and a write and read to the same index in cycle N, the cycle N+1 output is the OLD value. With BYPASS=1 it is the new value.
- Read-port select is a balanced 2:1 mux tree per bit, log2 depth levels. Per-port paths are identical, so no port is prioritised.
- Inputs carrying X on unused ports must not corrupt storage or other ports.

Test Plan:
1. Reset then read: reset=1 for 1 edge, then read all indices on every port -> all rd_data=0 (READ_REG=0: same cycle; READ_REG=1: next cycle).
2. Write/readback: write reg[i]=64'h1<<i for i=0..30, then read i on port0 and 30-i on port1 -> port0=1<<i and port1=1<<(30-i), each matching its own address.
3. XZR: wr_en=1, wr_addr=31, wr_data=64'hDEAD_BEEF_0000_0001 with rd_addr[0]=31 in the same cycle, then read 31 later -> 0 in both cycles, and regs 0..30 unchanged.
4. Bypass: reg[5]=64'hA; same cycle wr_en=1, wr_addr=5, wr_data=64'hB with rd_addr[0]=rd_addr[1]=5 -> both ports read B that cycle (BYPASS=1) or A (BYPASS=0); the next cycle both read B.
5. Reset mid-operation: reg[3]=64'h55; assert reset with wr_en=1, wr_addr=3, wr_data=64'h77 -> after the edge reg[3]=0 (not 77), and during that cycle rd_addr=3 shows no bypass of 77.
6. Non-power-of-two: DEPTH=24, ZERO_REG=23; write to addr 27 and read addr 27 -> write ignored, read returns 0; reg[22] write/readback works.
